// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 code constants, command FSM states and event layout
package ps2_pkg;

   localparam logic [7:0] ACK     = 8'hFA;
   localparam logic [7:0] RESEND  = 8'hFE;
   localparam logic [7:0] EXT     = 8'hE0;
   localparam logic [7:0] BRK     = 8'hF0;
   localparam logic [7:0] PAUSE   = 8'hE1;
   localparam logic [7:0] SET_LED = 8'hED;
   localparam logic [7:0] BAT     = 8'hAA;
   localparam logic [7:0] ECHO    = 8'hEE;
   localparam logic [7:0] KBD_ERR = 8'h00;
   localparam logic [7:0] KBD_OVR = 8'hFF;

   localparam int EVT_W        = 10;
   localparam int EVT_BRK_BIT  = 9;
   localparam int EVT_EXT_BIT  = 8;
   localparam int EVT_CODE_MSB = 7;

   // Bytes of the Pause make sequence that follow the leading E1
   localparam int PAUSE_SKIP = 7;

   typedef enum logic [2:0] {
      CMD_IDLE,
      CMD_WAIT_TX1,
      CMD_WAIT_ACK1,
      CMD_WAIT_TX2,
      CMD_WAIT_ACK2
   } cmd_state_e;

   function automatic logic [EVT_W-1:0] make_evt(input logic brk, input logic ext,
                                                 input logic [7:0] code);
      logic [EVT_W-1:0] evt;
      evt                          = '0;
      evt[EVT_BRK_BIT]             = brk;
      evt[EVT_EXT_BIT]             = ext;
      evt[EVT_CODE_MSB:0]          = code;
      return evt;
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - first-word-fall-through event FIFO with occupancy count
module ps2_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 10
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // A push into a full FIFO is still taken when a pop frees the head slot
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_comb begin
      empty_o = (count_q == '0);
      full_o  = (count_q == CW'(DEPTH));
      count_o = count_q;
      data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   end

endmodule

// File: rtl/ps2_kbd_controller.sv
// rtl/ps2_kbd_controller.sv - PS/2 scan-code sequencer, key-event queue and Set-LEDs command engine
module ps2_kbd_controller #(
   parameter int FIFO_DEPTH  = 8,
   parameter int ACK_TIMEOUT = 1000000,
   parameter int MAX_RETRY   = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [7:0]                     rx_byte,
   input  logic                           rx_valid,
   output logic [7:0]                     tx_byte,
   output logic                           tx_start,
   input  logic                           tx_done,
   input  logic [2:0]                     led_state,
   input  logic                           led_update,
   output logic [9:0]                     evt_data,
   output logic                           evt_valid,
   input  logic                           evt_pop,
   output logic [$clog2(FIFO_DEPTH):0]    evt_count,
   output logic                           overflow,
   output logic                           cmd_busy,
   output logic                           cmd_err
);
   import ps2_pkg::*;

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(ACK_TIMEOUT - 1);

   // Scan-code decoder
   logic             ext_q, ext_d;
   logic             brk_q, brk_d;
   logic [2:0]       skip_q, skip_d;
   logic             fifo_push;
   logic [EVT_W-1:0] fifo_wdata;
   logic             fifo_full, fifo_empty;
   logic             overflow_q, overflow_d;

   always_comb begin
      ext_d      = ext_q;
      brk_d      = brk_q;
      skip_d     = skip_q;
      fifo_push  = 1'b0;
      fifo_wdata = make_evt(brk_q, ext_q, rx_byte);
      if (rx_valid) begin
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
               fifo_push  = 1'b1;
               fifo_wdata = make_evt(1'b0, 1'b1, PAUSE);
            end
         end else begin
            unique case (rx_byte)
               EXT:     ext_d = 1'b1;
               BRK:     brk_d = 1'b1;
               PAUSE: begin
                  skip_d = 3'(PAUSE_SKIP);
                  ext_d  = 1'b0;
                  brk_d  = 1'b0;
               end
               ACK, RESEND: ;
               BAT, ECHO, KBD_ERR, KBD_OVR: begin
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
               default: begin
                  fifo_push = 1'b1;
                  ext_d     = 1'b0;
                  brk_d     = 1'b0;
               end
            endcase
         end
      end
   end

   // A full FIFO is never empty, so evt_pop there is always a real pop
   assign overflow_d = overflow_q | (fifo_push & fifo_full & ~evt_pop);

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (fifo_push),
      .data_i  (fifo_wdata),
      .pop_i   (evt_pop),
      .data_o  (evt_data),
      .count_o (evt_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // LED command FSM
   cmd_state_e    state_q, state_d;
   logic [2:0]    arg_q, arg_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          pending_q, pending_d;
   logic          cmd_err_q, cmd_err_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          tx_start_q, tx_start_d;
   logic          ack_rx, resend_rx;
   logic [7:0]    arg_byte;

   assign ack_rx    = rx_valid & (rx_byte == ACK);
   assign resend_rx = rx_valid & (rx_byte == RESEND);
   assign arg_byte  = {5'b0, arg_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         skip_q     <= '0;
         overflow_q <= 1'b0;
         state_q    <= CMD_IDLE;
         arg_q      <= '0;
         retry_q    <= '0;
         timer_q    <= '0;
         pending_q  <= 1'b0;
         cmd_err_q  <= 1'b0;
         tx_byte_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         ext_q      <= ext_d;
         brk_q      <= brk_d;
         skip_q     <= skip_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         arg_q      <= arg_d;
         retry_q    <= retry_d;
         timer_q    <= timer_d;
         pending_q  <= pending_d;
         cmd_err_q  <= cmd_err_d;
         tx_byte_q  <= tx_byte_d;
         tx_start_q <= tx_start_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      arg_d      = arg_q;
      retry_d    = retry_q;
      timer_d    = timer_q;
      pending_d  = pending_q | (led_update & (state_q != CMD_IDLE));
      cmd_err_d  = cmd_err_q;
      tx_byte_d  = tx_byte_q;
      tx_start_d = 1'b0;
      unique case (state_q)
         CMD_IDLE: begin
            if (led_update || pending_q) begin
               arg_d      = led_state;
               pending_d  = 1'b0;
               retry_d    = '0;
               tx_byte_d  = SET_LED;
               tx_start_d = 1'b1;
               state_d    = CMD_WAIT_TX1;
            end
         end
         CMD_WAIT_TX1, CMD_WAIT_TX2: begin
            if (tx_done) begin
               timer_d = TIMER_LOAD;
               state_d = (state_q == CMD_WAIT_TX1) ? CMD_WAIT_ACK1 : CMD_WAIT_ACK2;
            end
         end
         CMD_WAIT_ACK1, CMD_WAIT_ACK2: begin
            timer_d = timer_q - TW'(1);
            if (ack_rx) begin
               retry_d = '0;
               if (state_q == CMD_WAIT_ACK1) begin
                  tx_byte_d  = arg_byte;
                  tx_start_d = 1'b1;
                  state_d    = CMD_WAIT_TX2;
               end else begin
                  state_d = CMD_IDLE;
               end
            end else if (resend_rx || timer_q == '0) begin
               // Resend and expiry landing together fold into one retry
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d    = retry_q + RW'(1);
                  tx_start_d = 1'b1;
                  tx_byte_d  = (state_q == CMD_WAIT_ACK1) ? SET_LED : arg_byte;
                  state_d    = (state_q == CMD_WAIT_ACK1) ? CMD_WAIT_TX1 : CMD_WAIT_TX2;
               end else begin
                  cmd_err_d = 1'b1;
                  state_d   = CMD_IDLE;
               end
            end
         end
         default: state_d = CMD_IDLE;
      endcase
   end

   always_comb begin
      tx_byte   = tx_byte_q;
      tx_start  = tx_start_q;
      cmd_busy  = (state_q != CMD_IDLE);
      cmd_err   = cmd_err_q;
      overflow  = overflow_q;
      evt_valid = ~fifo_empty;
   end

endmodule

// File: tb/tb_ps2_kbd_controller.sv
// tb/tb_ps2_kbd_controller.sv - randomized and directed bench with a queue-based key-event model
module tb_ps2_kbd_controller;
   localparam int DEPTH = 8;
   localparam int TMO   = 16;
   localparam int MAXR  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_byte;
   logic       tx_start;
   logic       tx_done = 1'b0;
   logic [2:0] led_state = 3'd0;
   logic       led_update = 1'b0;
   logic [9:0] evt_data;
   logic       evt_valid;
   logic       evt_pop = 1'b0;
   logic [3:0] evt_count;
   logic       overflow;
   logic       cmd_busy;
   logic       cmd_err;

   always #5 clk = ~clk;

   ps2_kbd_controller #(
      .FIFO_DEPTH  (DEPTH),
      .ACK_TIMEOUT (TMO),
      .MAX_RETRY   (MAXR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .tx_byte    (tx_byte),
      .tx_start   (tx_start),
      .tx_done    (tx_done),
      .led_state  (led_state),
      .led_update (led_update),
      .evt_data   (evt_data),
      .evt_valid  (evt_valid),
      .evt_pop    (evt_pop),
      .evt_count  (evt_count),
      .overflow   (overflow),
      .cmd_busy   (cmd_busy),
      .cmd_err    (cmd_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   int td_cyc = 0;
   logic [7:0] sent_q[$];
   logic [7:0] disc [4] = '{8'hAA, 8'hEE, 8'h00, 8'hFF};

   // Key-event model: list of pending events plus decoder context
   logic [9:0] mq[$];
   bit         m_ovf = 1'b0;
   bit         m_ext = 1'b0;
   bit         m_brk = 1'b0;
   int         m_skip = 0;

   function automatic void decode(input logic [7:0] b, output bit have, output logic [9:0] ev);
      have = 1'b0;
      ev   = '0;
      if (m_skip > 0) begin
         m_skip--;
         if (m_skip == 0) begin
            have = 1'b1;
            ev   = 10'h1E1;
         end
      end else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE1) begin
         m_skip = 7;
         m_ext  = 1'b0;
         m_brk  = 1'b0;
      end else if (b == 8'hFA || b == 8'hFE) begin
         have = 1'b0;
      end else if (b == 8'hAA || b == 8'hEE || b == 8'h00 || b == 8'hFF) begin
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else begin
         have  = 1'b1;
         ev    = {m_brk, m_ext, b};
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   always @(posedge clk) begin
      bit         pop_ok;
      bit         have;
      logic [9:0] ev;
      int         size0;
      if (rst) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_ext  = 1'b0;
         m_brk  = 1'b0;
         m_skip = 0;
      end else begin
         size0  = mq.size();
         pop_ok = evt_pop && (size0 > 0);
         have   = 1'b0;
         ev     = '0;
         if (rx_valid) decode(rx_byte, have, ev);
         if (pop_ok) void'(mq.pop_front());
         if (have) begin
            if (size0 == DEPTH && !pop_ok) m_ovf = 1'b1;
            else mq.push_back(ev);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // One clock: sample at the falling edge, compare against the model, clear strobes
   task automatic tick();
      @(negedge clk);
      cyc_n++;
      chk("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
      chk("evt_count", 32'(evt_count), 32'(mq.size()));
      if (mq.size() != 0) chk("evt_data", 32'(evt_data), 32'(mq[0]));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (tx_start) sent_q.push_back(tx_byte);
      rx_valid   = 1'b0;
      evt_pop    = 1'b0;
      tx_done    = 1'b0;
      led_update = 1'b0;
   endtask

   task automatic rx(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick();
   endtask

   task automatic frame_done();
      tick();
      tick();
      tx_done = 1'b1;
      tick();
      td_cyc = cyc_n;
   endtask

   task automatic expect_tx(input string name, input logic [7:0] b, input bit chk_gap);
      int n = 0;
      while (sent_q.size() == 0 && n < 3 * TMO) begin
         tick();
         n++;
      end
      if (sent_q.size() == 0) chk(name, 32'(sent_q.size()), 32'd1);
      else begin
         chk(name, 32'(sent_q.pop_front()), 32'(b));
         if (chk_gap) chk("timeout_gap", 32'((cyc_n - td_cyc) >= TMO && (cyc_n - td_cyc) <= TMO + 2), 32'd1);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (mq.size() != 0 && n < 4 * DEPTH) begin
         evt_pop = 1'b1;
         tick();
         n++;
      end
      chk("drain_empty", 32'(evt_count), 32'd0);
   endtask

   initial begin
      int         r;
      int         n;
      logic [7:0] b;

      rst = 1'b1;
      repeat (3) tick();
      chk("rst_tx_byte", 32'(tx_byte), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_busy", 32'(cmd_busy), 32'd0);
      chk("rst_err", 32'(cmd_err), 32'd0);
      chk("rst_valid", 32'(evt_valid), 32'd0);
      rst = 1'b0;
      tick();

      // Single make code, next-cycle visibility, pop
      rx(8'h1C);
      chk("lat_valid", 32'(evt_valid), 32'd1);
      chk("lat_data", 32'(evt_data), 32'h01C);
      evt_pop = 1'b1;
      tick();
      chk("pop_count", 32'(evt_count), 32'd0);

      // Prefixed codes
      rx(8'hE0); rx(8'hF0); rx(8'h75);
      chk("ext_brk", 32'(evt_data), 32'h375);
      rx(8'hF0); rx(8'h1C);
      chk("brk_count", 32'(evt_count), 32'd2);
      evt_pop = 1'b1;
      tick();
      chk("brk_data", 32'(evt_data), 32'h21C);
      rx(8'h1C);
      drain();

      // Pause sequence
      rx(8'hE1); rx(8'h14); rx(8'h77); rx(8'hE1);
      rx(8'hF0); rx(8'h14); rx(8'hF0); rx(8'h77);
      chk("pause_count", 32'(evt_count), 32'd1);
      chk("pause_data", 32'(evt_data), 32'h1E1);
      rx(8'h1C);
      chk("after_pause", 32'(evt_count), 32'd2);
      drain();

      // Overflow, then push+pop on a full FIFO
      chk("ovf_before", 32'(overflow), 32'd0);
      for (int i = 0; i < 9; i++) rx(8'h10 + 8'(i));
      chk("full_count", 32'(evt_count), 32'd8);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("full_head", 32'(evt_data), 32'h010);
      evt_pop = 1'b1;
      rx(8'h20);
      chk("full_pushpop", 32'(evt_count), 32'd8);
      for (int i = 0; i < 7; i++) begin
         evt_pop = 1'b1;
         tick();
      end
      chk("newest_kept", 32'(evt_data), 32'h020);
      drain();

      // Randomized scan traffic
      for (int i = 0; i < 400; i++) begin
         r       = $urandom_range(0, 99);
         evt_pop = ($urandom_range(0, 9) < 4);
         if (r < 12) b = 8'hE0;
         else if (r < 24) b = 8'hF0;
         else if (r < 27) b = 8'hE1;
         else if (r < 33) b = disc[$urandom_range(0, 3)];
         else if (r < 36) b = 8'hFA;
         else b = 8'($urandom);
         if (r < 90) rx(b);
         else tick();
      end
      repeat (8) rx(8'h00);
      drain();
      sent_q.delete();

      // Set LEDs, clean handshake
      led_state  = 3'd5;
      led_update = 1'b1;
      tick();
      expect_tx("ed_1", 8'hED, 1'b0);
      chk("busy_1", 32'(cmd_busy), 32'd1);
      frame_done();
      rx(8'hFA);
      expect_tx("arg_1", 8'h05, 1'b0);
      frame_done();
      rx(8'hFA);
      tick();
      chk("done_busy", 32'(cmd_busy), 32'd0);
      chk("done_err", 32'(cmd_err), 32'd0);
      chk("evt_none", 32'(evt_count), 32'd0);

      // Resend of the argument byte
      led_update = 1'b1;
      tick();
      expect_tx("ed_2", 8'hED, 1'b0);
      frame_done();
      rx(8'hFA);
      expect_tx("arg_2", 8'h05, 1'b0);
      frame_done();
      rx(8'hFE);
      expect_tx("arg_resend", 8'h05, 1'b0);
      frame_done();
      rx(8'hFA);
      repeat (5) tick();
      chk("resend_busy", 32'(cmd_busy), 32'd0);
      chk("resend_extra", 32'(sent_q.size()), 32'd0);

      // No ACK at all: initial send plus MAX_RETRY retries, then abort
      led_state  = 3'd2;
      led_update = 1'b1;
      tick();
      for (int i = 0; i <= MAXR; i++) begin
         expect_tx("ed_tmo", 8'hED, i > 0);
         frame_done();
      end
      n = 0;
      while (cmd_busy && n < 3 * TMO) begin
         tick();
         n++;
      end
      chk("tmo_err", 32'(cmd_err), 32'd1);
      chk("tmo_idle", 32'(cmd_busy), 32'd0);
      repeat (2 * TMO) tick();
      chk("tmo_no_fifth", 32'(sent_q.size()), 32'd0);

      // Requests during a busy command collapse into one follow-up with the latest value
      led_state  = 3'd1;
      led_update = 1'b1;
      tick();
      expect_tx("ed_p", 8'hED, 1'b0);
      led_state  = 3'd2;
      led_update = 1'b1;
      tick();
      led_state  = 3'd6;
      led_update = 1'b1;
      tick();
      frame_done();
      rx(8'hFA);
      expect_tx("arg_p", 8'h01, 1'b0);
      frame_done();
      rx(8'hFA);
      expect_tx("ed_follow", 8'hED, 1'b0);
      frame_done();
      rx(8'hFA);
      expect_tx("arg_follow", 8'h06, 1'b0);
      frame_done();
      rx(8'hFA);
      repeat (30) tick();
      chk("follow_once", 32'(sent_q.size()), 32'd0);
      chk("follow_idle", 32'(cmd_busy), 32'd0);
      chk("err_sticky", 32'(cmd_err), 32'd1);

      // Reset while waiting for the first ACK
      rx(8'h1C);
      led_update = 1'b1;
      tick();
      expect_tx("ed_rst", 8'hED, 1'b0);
      frame_done();
      tick();
      chk("pre_rst_busy", 32'(cmd_busy), 32'd1);
      rst = 1'b1;
      tick();
      chk("mid_rst_tx_byte", 32'(tx_byte), 32'd0);
      chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
      chk("mid_rst_busy", 32'(cmd_busy), 32'd0);
      chk("mid_rst_err", 32'(cmd_err), 32'd0);
      chk("mid_rst_data", 32'(evt_data), 32'd0);
      rst = 1'b0;
      repeat (3 * TMO) tick();
      chk("rst_no_tx", 32'(sent_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_controller.md
Name: ps2_kbd_controller

Overview:
Sequencing layer between the PS/2 frame receiver/transmitter and the CPU bus. Assembles multi-byte scan-code sequences (E0/F0/E1 prefixes) into single key events and queues them in a FIFO. Also runs the host-to-keyboard "Set LEDs" command (ED, arg) with ACK wait, resend and timeout handling. The frame receiver delivers bytes plus a valid pulse. The frame transmitter takes a byte plus a start pulse and reports done.

Parameters:
FIFO_DEPTH, 8, key-event FIFO entries; power of two, >= 2
ACK_TIMEOUT, 1000000, cycles from tx_done to ACK before a retry (20 ms at 50 MHz)
MAX_RETRY, 3, resend attempts per byte before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_byte  in  8  byte from frame receiver
rx_valid  in  1  one-cycle strobe, rx_byte valid
tx_byte  out  8  byte to frame transmitter
tx_start  out  1  one-cycle strobe, start transmission
tx_done  in  1  one-cycle strobe, transmitter finished frame
led_state  in  3  {caps, num, scroll} requested LED value
led_update  in  1  one-cycle strobe, send led_state to keyboard
evt_data  out  10  FIFO head: {brk, ext, code[7:0]}
evt_valid  out  1  FIFO non-empty
evt_pop  in  1  consume head; ignored when empty
evt_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: event dropped on full FIFO
cmd_busy  out  1  LED command in progress
cmd_err  out  1  sticky: LED command aborted after MAX_RETRY

Behaviour:
- Reset: all outputs 0; tx_byte=00; FIFO empty; prefix flags and pending clear; FSM IDLE. Reset mid-command abandons it silently, with no tx_start afterwards. overflow and cmd_err clear only on rst.
- Decoder, on rx_valid:
  - E0 sets ext.
  - F0 sets brk.
  - E1 enters a pause skip: the next 7 bytes are discarded, then one event {0,1,E1} is pushed.
  - FA and FE are routed to the command FSM only; they never produce events.
  - AA, EE, 00 and FF are discarded and clear the flags.
  - Any other byte pushes {brk, ext, byte} and clears brk/ext.
- Latency: rx_valid at cycle N into an empty FIFO -> evt_valid=1 at N+1.
- FIFO: first-word-fall-through, evt_data = head.
  - Push when full: event dropped, overflow=1.
  - Push and pop in the same cycle: count unchanged, including when full (the push is accepted).
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Command FSM states:
  - IDLE: on led_update or pending, latch led_state into arg, clear pending and the retry counter, drive tx_byte=ED with tx_start=1 for one cycle -> WAIT_TX1.
  - WAIT_TX1: on tx_done, load the timeout counter -> WAIT_ACK1.
  - WAIT_ACK1:
    - FA: tx_byte={5'b0,arg}, tx_start pulse, retry counter cleared -> WAIT_TX2.
    - FE, or timeout expiry: if retries < MAX_RETRY, increment retries, re-send ED -> WAIT_TX1; else cmd_err=1 -> IDLE.
  - WAIT_TX2 and WAIT_ACK2: same as WAIT_TX1/WAIT_ACK1 for the arg byte. FA -> IDLE, command done.
- cmd_busy=1 in every state except IDLE.
- led_update while cmd_busy: pending=1 and arg is relatched at the next IDLE entry, so the latest led_state wins. Multiple requests collapse into one.
- Scan bytes arriving during WAIT_* go to the decoder normally.
- The timeout counter is counted down only in WAIT_ACK*. Expiry happens on the cycle it reaches 0.
- Simultaneous FE and timeout in one cycle count as a single retry.

Decomposition:
- Shared package ps2_pkg:
  - code constants: ACK=FA, RESEND=FE, EXT=E0, BRK=F0, PAUSE=E1, SET_LED=ED, BAT=AA, ECHO=EE
  - FSM state enum
  - event field offsets
- Sub-module ps2_event_fifo: parameterised FWFT FIFO with count and full/empty.

Test Plan:
- rx 1C -> one event 01C, evt_valid at N+1. Pop -> count 0.
- rx E0, F0, 75 -> single event 375. rx F0, 1C -> 21C. Flags clear afterwards.
- rx E1 14 77 E1 F0 14 F0 77 -> exactly one event 1E1. The following 1C -> 01C.
- Push 9 events with DEPTH=8 and no pops -> count 8, overflow=1, 9th dropped. Full with push+pop same cycle -> count stays 8, newest retained.
- led_update with led_state=5:
  - ED sent; FA reply -> arg 05 sent; FA reply -> cmd_busy=0, cmd_err=0.
  - FE after the arg byte -> 05 re-sent.
- No ACK, ACK_TIMEOUT=16 -> ED sent 4 times, then cmd_err=1 and IDLE. A second led_update during busy -> exactly one follow-up command with the latest value. rst mid-WAIT_ACK1 -> all outputs 0.
